reset_sequencer: RTL and testbench



---
 rtl/reset_sequencer.sv | 124 ++++++++++++
 tb/tb_reset_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// reset_sequencer
// Holds every downstream reset for a minimum width, then frees the stages
// one at a time. Each release waits out a programmable delay and a ready
// handshake from the stage freed before it. A software request from the
// processor, honoured only once everything is running, restarts the whole
// sequence and is answered with a one-cycle acknowledge.
module reset_sequencer #(
  parameter int N_STAGES   = 3,
  parameter int MIN_ASSERT = 8,
  parameter int STAGE_DLY  = 16,
  parameter int CNT_W      = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                soft_rst_req,
  input  logic [N_STAGES-1:0] stage_ok,
  output logic [N_STAGES-1:0] rst_out,
  output logic                seq_done,
  output logic                soft_rst_ack
);

  localparam int IDX_W = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

  localparam logic [CNT_W-1:0] ASSERT_LAST = CNT_W'(MIN_ASSERT - 1);
  localparam logic [CNT_W-1:0] DLY_LAST    = CNT_W'(STAGE_DLY - 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(N_STAGES - 1);

  typedef enum logic [1:0] {
    ST_ASSERT,
    ST_RELEASE,
    ST_RUN
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic             prev_ok;

  // Ready flag of the stage freed just before the one now waiting (idx-1).
  // A loop is used rather than a direct index so a single-stage build needs
  // no out-of-range selects.
  always_comb begin
    prev_ok = 1'b0;
    for (int k = 0; k < N_STAGES; k++) begin
      if (k + 1 == int'(idx)) begin
        prev_ok = stage_ok[k];
      end
    end
  end

  // Sequencer state machine; every output is a register so the downstream
  // resets are glitch-free and change only on clock edges (or on reset).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= ST_ASSERT;
      cnt          <= '0;
      idx          <= '0;
      rst_out      <= '1;
      seq_done     <= 1'b0;
      soft_rst_ack <= 1'b0;
    end else begin
      soft_rst_ack <= 1'b0;
      case (state)
        ST_ASSERT: begin
          if (cnt == ASSERT_LAST) begin
            rst_out[0] <= 1'b0;
            cnt        <= '0;
            if (N_STAGES == 1) begin
              state    <= ST_RUN;
              seq_done <= 1'b1;
            end else begin
              idx   <= IDX_W'(1);
              state <= ST_RELEASE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ST_RELEASE: begin
          if (cnt != DLY_LAST) begin
            cnt <= cnt + CNT_W'(1);
          end else if (prev_ok) begin
            for (int k = 1; k < N_STAGES; k++) begin
              if (k == int'(idx)) begin
                rst_out[k] <= 1'b0;
              end
            end
            cnt <= '0;
            if (idx == LAST_IDX) begin
              state    <= ST_RUN;
              seq_done <= 1'b1;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end

        ST_RUN: begin
          if (soft_rst_req) begin
            rst_out      <= '1;
            seq_done     <= 1'b0;
            soft_rst_ack <= 1'b1;
            cnt          <= '0;
            idx          <= '0;
            state        <= ST_ASSERT;
          end else begin
            rst_out  <= '0;
            seq_done <= 1'b1;
          end
        end

        default: begin
          state    <= ST_ASSERT;
          cnt      <= '0;
          idx      <= '0;
          rst_out  <= '1;
          seq_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer
// Directed checks of reset_sequencer: a default three-stage instance and a
// single-stage, minimum-width instance share one clock.
module tb_reset_sequencer;

  logic       clock = 1'b0;

  // Default instance (3 stages, 8 / 16 edges)
  logic       reset = 1'b1;
  logic       soft_rst_req = 1'b0;
  logic [2:0] stage_ok = 3'b111;
  logic [2:0] rst_out;
  logic       seq_done;
  logic       soft_rst_ack;

  // Corner instance (1 stage, MIN_ASSERT = 1)
  logic       reset_c = 1'b1;
  logic       soft_rst_req_c = 1'b0;
  logic [0:0] stage_ok_c = 1'b1;
  logic [0:0] rst_out_c;
  logic       seq_done_c;
  logic       soft_rst_ack_c;

  int check_count = 0;
  int pass_count  = 0;
  int ack_count   = 0;
  int ack_base    = 0;
  int edge_no     = 0;

  reset_sequencer #(
    .N_STAGES(3), .MIN_ASSERT(8), .STAGE_DLY(16), .CNT_W(8)
  ) dut (
    .clock(clock), .reset(reset), .soft_rst_req(soft_rst_req),
    .stage_ok(stage_ok), .rst_out(rst_out), .seq_done(seq_done),
    .soft_rst_ack(soft_rst_ack)
  );

  reset_sequencer #(
    .N_STAGES(1), .MIN_ASSERT(1), .STAGE_DLY(16), .CNT_W(8)
  ) dut_c (
    .clock(clock), .reset(reset_c), .soft_rst_req(soft_rst_req_c),
    .stage_ok(stage_ok_c), .rst_out(rst_out_c), .seq_done(seq_done_c),
    .soft_rst_ack(soft_rst_ack_c)
  );

  always #5 clock = ~clock;

  // Count acknowledge cycles of the default instance just after each edge
  always @(posedge clock) begin
    #1;
    if (soft_rst_ack) ack_count++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, actual, expected, $time);
    end else begin
      pass_count++;
    end
  endtask

  task automatic advance_to(input int target);
    while (edge_no < target) begin
      @(negedge clock);
      edge_no++;
    end
  endtask

  // Pulse reset on the default instance; returns at edge 0 of a fresh sequence
  task automatic applyStimulus();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    edge_no = 0;
  endtask

  initial begin
    $display("[TB] starting reset_sequencer checks");

    // Power-up with all stages ready
    @(negedge clock);
    applyStimulus();
    ack_base = ack_count;
    checkOutput("t1_rst_e0", 32'(rst_out), 32'h7);
    checkOutput("t1_done_e0", 32'(seq_done), 32'h0);
    advance_to(7);
    checkOutput("t1_rst_e7", 32'(rst_out), 32'h7);
    advance_to(8);
    checkOutput("t1_rst_e8", 32'(rst_out), 32'h6);
    advance_to(23);
    checkOutput("t1_rst_e23", 32'(rst_out), 32'h6);
    advance_to(24);
    checkOutput("t1_rst_e24", 32'(rst_out), 32'h4);
    advance_to(39);
    checkOutput("t1_rst_e39", 32'(rst_out), 32'h4);
    checkOutput("t1_done_e39", 32'(seq_done), 32'h0);
    advance_to(40);
    checkOutput("t1_rst_e40", 32'(rst_out), 32'h0);
    checkOutput("t1_done_e40", 32'(seq_done), 32'h1);
    checkOutput("t1_no_ack", 32'(ack_count - ack_base), 32'h0);

    // Stage 0 ready late: stage 1 release stalls until edge 50
    stage_ok = 3'b110;
    applyStimulus();
    advance_to(8);
    checkOutput("t2_rst_e8", 32'(rst_out), 32'h6);
    advance_to(49);
    checkOutput("t2_rst_e49", 32'(rst_out), 32'h6);
    stage_ok = 3'b111;
    advance_to(50);
    checkOutput("t2_rst_e50", 32'(rst_out), 32'h4);
    advance_to(65);
    checkOutput("t2_rst_e65", 32'(rst_out), 32'h4);
    checkOutput("t2_done_e65", 32'(seq_done), 32'h0);
    advance_to(66);
    checkOutput("t2_rst_e66", 32'(rst_out), 32'h0);
    checkOutput("t2_done_e66", 32'(seq_done), 32'h1);

    // Software reset while running
    ack_base = ack_count;
    soft_rst_req = 1'b1;
    @(negedge clock);
    soft_rst_req = 1'b0;
    edge_no = 0;
    checkOutput("t3_rst_e0", 32'(rst_out), 32'h7);
    checkOutput("t3_done_e0", 32'(seq_done), 32'h0);
    checkOutput("t3_ack_e0", 32'(soft_rst_ack), 32'h1);
    advance_to(1);
    checkOutput("t3_ack_e1", 32'(soft_rst_ack), 32'h0);
    advance_to(7);
    checkOutput("t3_rst_e7", 32'(rst_out), 32'h7);
    advance_to(8);
    checkOutput("t3_rst_e8", 32'(rst_out), 32'h6);
    advance_to(24);
    checkOutput("t3_rst_e24", 32'(rst_out), 32'h4);
    advance_to(40);
    checkOutput("t3_rst_e40", 32'(rst_out), 32'h0);
    checkOutput("t3_done_e40", 32'(seq_done), 32'h1);
    checkOutput("t3_ack_count", 32'(ack_count - ack_base), 32'h1);

    // Software request during sequencing is ignored
    applyStimulus();
    ack_base = ack_count;
    advance_to(9);
    soft_rst_req = 1'b1;
    advance_to(20);
    soft_rst_req = 1'b0;
    checkOutput("t4_rst_e20", 32'(rst_out), 32'h6);
    advance_to(23);
    checkOutput("t4_rst_e23", 32'(rst_out), 32'h6);
    advance_to(24);
    checkOutput("t4_rst_e24", 32'(rst_out), 32'h4);
    advance_to(40);
    checkOutput("t4_rst_e40", 32'(rst_out), 32'h0);
    checkOutput("t4_done_e40", 32'(seq_done), 32'h1);
    checkOutput("t4_no_ack", 32'(ack_count - ack_base), 32'h0);

    // Asynchronous reset between edges 30 and 31
    applyStimulus();
    advance_to(30);
    checkOutput("t5_rst_e30", 32'(rst_out), 32'h4);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("t5_rst_async", 32'(rst_out), 32'h7);
    checkOutput("t5_done_async", 32'(seq_done), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    edge_no = 0;
    advance_to(7);
    checkOutput("t5_rst_e7", 32'(rst_out), 32'h7);
    advance_to(8);
    checkOutput("t5_rst_e8", 32'(rst_out), 32'h6);
    advance_to(24);
    checkOutput("t5_rst_e24", 32'(rst_out), 32'h4);
    advance_to(40);
    checkOutput("t5_rst_e40", 32'(rst_out), 32'h0);

    // Single stage with the shortest assert width
    reset_c = 1'b1;
    @(negedge clock);
    reset_c = 1'b0;
    checkOutput("t6_rst_e0", 32'(rst_out_c), 32'h1);
    checkOutput("t6_done_e0", 32'(seq_done_c), 32'h0);
    @(negedge clock);
    checkOutput("t6_rst_e1", 32'(rst_out_c), 32'h0);
    checkOutput("t6_done_e1", 32'(seq_done_c), 32'h1);
    soft_rst_req_c = 1'b1;
    @(negedge clock);
    soft_rst_req_c = 1'b0;
    checkOutput("t6_soft_rst", 32'(rst_out_c), 32'h1);
    checkOutput("t6_soft_ack", 32'(soft_rst_ack_c), 32'h1);
    checkOutput("t6_soft_done", 32'(seq_done_c), 32'h0);
    @(negedge clock);
    checkOutput("t6_rel_rst", 32'(rst_out_c), 32'h0);
    checkOutput("t6_rel_ack", 32'(soft_rst_ack_c), 32'h0);
    checkOutput("t6_rel_done", 32'(seq_done_c), 32'h1);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
